uart_cmd_ctrl: RTL and testbench

Command-frame controller behind the UART receiver. It consumes the received byte stream (`rx_data`/`rx_valid`), parses fixed 5-byte command frames, and sequences register-file writes and reads. Read results are returned on a ready/valid byte stream toward the UART transmit path. Frame errors and timeouts are counted in a saturating counter.

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_cmd_timeout.sv | 34 +++
 rtl/uart_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

    // Frame-parser / executor states
    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC_WR,
        EXEC_RD,
        RD_WAIT,
        RESP
    } state_e;

    localparam logic [7:0] CMD_WR            = 8'h01;
    localparam logic [7:0] CMD_RD            = 8'h02;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // True when no address bit at or above addr_w is set
    function automatic logic addr_in_range(input logic [7:0] addr, input int unsigned addr_w);
        return (addr >> addr_w) == 8'h00;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: pulses expire on the last idle cycle allowed
// inside a frame, unless a byte arrives (clear) on that same cycle.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Count idle cycles while enabled; any byte or leaving the frame restarts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || !enable || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // A byte on the expiry cycle wins, so clear masks the pulse
    assign expire = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: parses SYNC/CMD/ADDR/DATA/CHK frames from the
// UART receiver, issues register writes/reads and returns read data on a
// ready/valid byte stream. Frame errors, timeouts and overruns are counted.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    state_e     state_q, state_next;
    logic [7:0] cmd_q, addr_q, data_q;
    logic       in_frame;
    logic       expire;
    logic       frame_ok;
    logic       err_inc;

    assign in_frame = (state_q == GET_CMD)  || (state_q == GET_ADDR) ||
                      (state_q == GET_DATA) || (state_q == GET_CHK);

    // Checksum, command and address validity, evaluated against the CHK byte on the bus
    assign frame_ok = (rx_data == (cmd_q ^ addr_q ^ data_q)) &&
                      ((cmd_q == CMD_WR) || (cmd_q == CMD_RD)) &&
                      addr_in_range(addr_q, ADDR_W);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rx_valid),
        .enable(in_frame),
        .expire(expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_next;
    end

    // Next-state decode and error-event detection
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_next = state_q;
        err_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) state_next = GET_CMD;
            end
            GET_CMD, GET_ADDR, GET_DATA: begin
                if (rx_valid) begin
                    state_next = state_e'(state_q + 4'd1);
                end else if (expire) begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end
            end
            GET_CHK: begin
                if (rx_valid) begin
                    if (frame_ok) begin
                        state_next = (cmd_q == CMD_WR) ? EXEC_WR : EXEC_RD;
                    end else begin
                        state_next = IDLE;
                        err_inc    = 1'b1;
                    end
                end else if (expire) begin
                    state_next = IDLE;
                    err_inc    = 1'b1;
                end
            end
            EXEC_WR: begin
                state_next = IDLE;
                err_inc    = rx_valid;
            end
            EXEC_RD: begin
                state_next = RD_WAIT;
                err_inc    = rx_valid;
            end
            RD_WAIT: begin
                state_next = RESP;
                err_inc    = rx_valid;
            end
            RESP: begin
                if (tx_ready) state_next = IDLE;
                err_inc = rx_valid;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch frame fields as each byte arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= 8'h00;
            addr_q <= 8'h00;
            data_q <= 8'h00;
        end else if (rx_valid) begin
            case (state_q)
                GET_CMD:  cmd_q  <= rx_data;
                GET_ADDR: addr_q <= rx_data;
                GET_DATA: data_q <= rx_data;
                default:  ;
            endcase
        end
    end

    // Registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_data  <= 8'h00;
            tx_data  <= 8'h00;
        end else begin
            wr_en    <= (state_next == EXEC_WR);
            rd_en    <= (state_next == EXEC_RD);
            tx_valid <= (state_next == RESP);
            busy     <= (state_next != IDLE);
            if (state_next == EXEC_WR) begin
                wr_addr <= addr_q[ADDR_W-1:0];
                wr_data <= data_q;
            end
            if (state_next == EXEC_RD) begin
                rd_addr <= addr_q[ADDR_W-1:0];
            end
            // Read data is valid the cycle after rd_en, i.e. while in RD_WAIT
            if (state_q == RD_WAIT) begin
                tx_data <= rd_data;
            end
        end
    end

    // Saturating error counter, at most one increment per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (err_inc && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard-based bench for uart_cmd_ctrl: expected writes, read addresses
// and response bytes are queued as frames are sent and checked as the DUT
// produces them; each scenario task also checks cycle timing inline.
module tb_uart_cmd_ctrl;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned TIMEOUT = 100;
    localparam logic [7:0]  SYNC    = 8'hA5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = 8'h00;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;
    logic              busy;
    logic [7:0]        err_cnt;

    int                n_checks = 0;
    int                n_fail = 0;
    int                n_xfer = 0;
    logic [7:0]        rd_value = 8'h00;
    logic              rd_en_d = 1'b0;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    logic [7:0]        exp_tx[$];

    uart_cmd_ctrl #(
        .SYNC_BYTE     (SYNC),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // One clock: score any transfer at this edge, then sample outputs 1 unit after it
    task automatic tick();
        wr_t w;
        logic [7:0] t;
        logic [ADDR_W-1:0] a;
        if (tx_valid && tx_ready) begin
            n_checks++;
            n_xfer++;
            if (exp_tx.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tx: tx_data=%h with no response expected", tx_data);
            end else begin
                t = exp_tx.pop_front();
                if (tx_data !== t) begin
                    n_fail++;
                    $display("FAIL tx_data: got %h expected %h", tx_data, t);
                end
            end
        end
        @(posedge clk);
        #1;
        // Register-file model: read data valid only the cycle after rd_en
        rd_data = rd_en_d ? rd_value : ~rd_value;
        rd_en_d = rd_en;
        if (wr_en === 1'b1) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_wr: wr_addr=%h wr_data=%h", wr_addr, wr_data);
            end else begin
                w = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== {w.addr, w.data}) begin
                    n_fail++;
                    $display("FAIL wr_cmd: got addr=%h data=%h expected addr=%h data=%h",
                             wr_addr, wr_data, w.addr, w.data);
                end
            end
        end
        if (rd_en === 1'b1) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rd: rd_addr=%h", rd_addr);
            end else begin
                a = exp_rd.pop_front();
                if (rd_addr !== a) begin
                    n_fail++;
                    $display("FAIL rd_addr: got %h expected %h", rd_addr, a);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Returns sampled at N+1 where N is the CHK byte cycle
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                              input logic [7:0] data, input logic [7:0] chk, input int gap);
        send_byte(SYNC); idle(gap);
        send_byte(cmd);  idle(gap);
        send_byte(addr); idle(gap);
        send_byte(data); idle(gap);
        send_byte(chk);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tick();
        exp_wr.delete();
        exp_rd.delete();
        exp_tx.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_checks++;
        if ({wr_en, rd_en, tx_valid, busy, wr_addr, rd_addr, wr_data, tx_data, err_cnt} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected all zero",
                     {wr_en, rd_en, tx_valid, busy, wr_addr, rd_addr, wr_data, tx_data, err_cnt});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        do_reset();
        exp_wr.push_back('{4'h3, 8'h5C});
        send_frame(8'h01, 8'h03, 8'h5C, 8'h5E, 0);
        n_checks++;
        if ({wr_en, busy, wr_addr, wr_data} !== {1'b1, 1'b1, 4'h3, 8'h5C}) begin
            n_fail++;
            $display("FAIL write_n1: got wr_en=%b busy=%b addr=%h data=%h expected 1 1 3 5c",
                     wr_en, busy, wr_addr, wr_data);
        end
        tick();
        n_checks++;
        if ({wr_en, busy, wr_addr, wr_data, err_cnt} !== {1'b0, 1'b0, 4'h3, 8'h5C, 8'h00}) begin
            n_fail++;
            $display("FAIL write_n2: got wr_en=%b busy=%b addr=%h data=%h err=%h expected 0 0 3 5c 00",
                     wr_en, busy, wr_addr, wr_data, err_cnt);
        end
    endtask

    task automatic test_read_backpressure();
        int xfer0;
        do_reset();
        tx_ready = 1'b0;
        rd_value = 8'hC3;
        exp_rd.push_back(4'h7);
        exp_tx.push_back(8'hC3);
        send_frame(8'h02, 8'h07, 8'h00, 8'h05, 0);
        n_checks++;
        if ({rd_en, rd_addr, tx_valid} !== {1'b1, 4'h7, 1'b0}) begin
            n_fail++;
            $display("FAIL read_n1: got rd_en=%b rd_addr=%h tx_valid=%b expected 1 7 0", rd_en, rd_addr, tx_valid);
        end
        tick();
        n_checks++;
        if ({rd_en, tx_valid, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL read_n2: got rd_en=%b tx_valid=%b busy=%b expected 0 0 1", rd_en, tx_valid, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({tx_valid, tx_data} !== {1'b1, 8'hC3}) begin
                n_fail++;
                $display("FAIL read_hold[%0d]: got tx_valid=%b tx_data=%h expected 1 c3", i, tx_valid, tx_data);
            end
        end
        xfer0    = n_xfer;
        tx_ready = 1'b1;
        tick();
        n_checks++;
        if ({tx_valid, busy, err_cnt} !== {1'b0, 1'b0, 8'h00} || n_xfer != xfer0 + 1) begin
            n_fail++;
            $display("FAIL read_done: got tx_valid=%b busy=%b err=%h transfers=%0d expected 0 0 00 %0d",
                     tx_valid, busy, err_cnt, n_xfer - xfer0, 1);
        end
    endtask

    task automatic test_errors();
        logic [7:0] tbl [3][4];
        tbl[0] = '{8'h01, 8'h03, 8'h5C, 8'h00};
        tbl[1] = '{8'h07, 8'h03, 8'h5C, 8'h07 ^ 8'h03 ^ 8'h5C};
        tbl[2] = '{8'h01, 8'h13, 8'h5C, 8'h01 ^ 8'h13 ^ 8'h5C};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            send_frame(tbl[k][0], tbl[k][1], tbl[k][2], tbl[k][3], 0);
            n_checks++;
            if ({wr_en, rd_en, busy, err_cnt} !== {3'b000, 8'h01}) begin
                n_fail++;
                $display("FAIL reject[%0d]: got wr_en=%b rd_en=%b busy=%b err=%h expected 0 0 0 01",
                         k, wr_en, rd_en, busy, err_cnt);
            end
            idle(2);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(SYNC);
        send_byte(8'h01);
        idle(TIMEOUT - 1);
        n_checks++;
        if ({busy, err_cnt} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL timeout_early: got busy=%b err=%h expected 1 00", busy, err_cnt);
        end
        idle(1);
        n_checks++;
        if ({busy, err_cnt} !== {1'b0, 8'h01}) begin
            n_fail++;
            $display("FAIL timeout_expire: got busy=%b err=%h expected 0 01", busy, err_cnt);
        end
        // Every byte lands exactly on the expiry cycle
        do_reset();
        exp_wr.push_back('{4'h3, 8'h5C});
        send_frame(8'h01, 8'h03, 8'h5C, 8'h5E, TIMEOUT - 1);
        n_checks++;
        if ({wr_en, err_cnt} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL timeout_edge: got wr_en=%b err=%h expected 1 00", wr_en, err_cnt);
        end
        tick();
    endtask

    task automatic test_overrun_saturate();
        do_reset();
        tx_ready = 1'b0;
        rd_value = 8'h3A;
        exp_rd.push_back(4'h7);
        exp_tx.push_back(8'h3A);
        send_frame(8'h02, 8'h07, 8'h00, 8'h05, 0);
        idle(2);
        send_byte(SYNC);
        n_checks++;
        if ({err_cnt, tx_valid, tx_data} !== {8'h01, 1'b1, 8'h3A}) begin
            n_fail++;
            $display("FAIL overrun: got err=%h tx_valid=%b tx_data=%h expected 01 1 3a", err_cnt, tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        tick();
        n_checks++;
        if ({tx_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL overrun_done: got tx_valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h01, 8'h03, 8'h5C, 8'h00, 0);
            if (i == 252) begin
                n_checks++;
                if (err_cnt !== 8'hFE) begin
                    n_fail++;
                    $display("FAIL err_count_fe: got %h expected fe", err_cnt);
                end
            end
        end
        n_checks++;
        if (err_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_saturate: got %h expected ff", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        exp_wr.push_back('{4'h3, 8'h5C});
        send_frame(8'h01, 8'h03, 8'h5C, 8'h5E, 0);
        tick();
        send_byte(SYNC);
        send_byte(8'h01);
        send_byte(8'h03);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en, rd_en, tx_valid, busy, wr_addr, rd_addr, wr_data, tx_data, err_cnt} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_midframe: got %b expected all zero",
                     {wr_en, rd_en, tx_valid, busy, wr_addr, rd_addr, wr_data, tx_data, err_cnt});
        end
        idle(2);
        rst_n = 1'b1;
        tick();
        exp_wr.push_back('{4'h5, 8'hAA});
        send_frame(8'h01, 8'h05, 8'hAA, 8'h01 ^ 8'h05 ^ 8'hAA, 0);
        n_checks++;
        if ({wr_en, err_cnt} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL after_reset_wr: got wr_en=%b err=%h expected 1 00", wr_en, err_cnt);
        end
        tick();
        // Reset while holding a response
        tx_ready = 1'b0;
        rd_value = 8'h99;
        exp_rd.push_back(4'h2);
        exp_tx.push_back(8'h99);
        send_frame(8'h02, 8'h02, 8'h00, 8'h00, 0);
        idle(2);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en, rd_en, tx_valid, busy, wr_addr, rd_addr, wr_data, tx_data, err_cnt} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_resp: got %b expected all zero",
                     {wr_en, rd_en, tx_valid, busy, wr_addr, rd_addr, wr_data, tx_data, err_cnt});
        end
        exp_tx.delete();
        idle(2);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        tick();
        rd_value = 8'h6E;
        exp_rd.push_back(4'h4);
        exp_tx.push_back(8'h6E);
        send_frame(8'h02, 8'h04, 8'h00, 8'h06, 0);
        idle(2);
        n_checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h6E}) begin
            n_fail++;
            $display("FAIL after_reset_rd: got tx_valid=%b tx_data=%h expected 1 6e", tx_valid, tx_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_ready = 1'b1;
        exp_wr.push_back('{4'h1, 8'h11});
        send_frame(8'h01, 8'h01, 8'h11, 8'h01 ^ 8'h01 ^ 8'h11, 0);
        tick();
        rd_value = 8'h5A;
        exp_rd.push_back(4'h9);
        exp_tx.push_back(8'h5A);
        send_frame(8'h02, 8'h09, 8'h00, 8'h0B, 0);
        idle(2);
        n_checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL b2b_resp: got tx_valid=%b tx_data=%h expected 1 5a", tx_valid, tx_data);
        end
        tick();
        n_checks++;
        if ({tx_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_resp_len: got tx_valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        exp_wr.push_back('{4'hF, 8'h77});
        send_frame(8'h01, 8'h0F, 8'h77, 8'h01 ^ 8'h0F ^ 8'h77, 0);
        n_checks++;
        if ({wr_en, err_cnt} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL b2b_write: got wr_en=%b err=%h expected 1 00", wr_en, err_cnt);
        end
        tick();
    endtask

    task automatic test_drain();
        n_checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got wr=%0d rd=%0d tx=%0d pending expected 0 0 0",
                     exp_wr.size(), exp_rd.size(), exp_tx.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_errors();
        test_timeout();
        test_overrun_saturate();
        test_reset_mid();
        test_back_to_back();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
